sys_ctl: RTL and testbench

Reset and CPU clock-enable sequencer directly upstream of the system top level. It runs on the 28 MHz board clock and produces the active-low CPU reset (`cpu_reset_n`, wired to the system's `reset_n`) and the CPU clock-enable strobe (`cpu_clken`). It stretches power-on reset and debounces the front-panel reset button. An optional turbo selector changes the CPU enable rate.

---
 rtl/sys_ctl_pkg.sv | 17 +
 rtl/sys_ctl_debounce.sv | 40 ++++
 rtl/sys_ctl.sv | 142 ++++++++++++++
 tb/tb_sys_ctl.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/sys_ctl_pkg.sv
// Shared types and constants for the sys_ctl reset / clock-enable sequencer.
package sys_ctl_pkg;

    // Sequencer states: stretching reset, CPU running, button held down.
    typedef enum logic [1:0] {
        HOLD = 2'd0,
        RUN  = 2'd1,
        BTN  = 2'd2
    } sys_state_t;

    // Turbo select encodings; each step halves the cpu_clken divisor.
    localparam logic [1:0] TURBO_X1 = 2'b00;
    localparam logic [1:0] TURBO_X2 = 2'b01;
    localparam logic [1:0] TURBO_X4 = 2'b10;
    localparam logic [1:0] TURBO_X8 = 2'b11;

endpackage

// File: rtl/sys_ctl_debounce.sv
// Front-panel button conditioning: 2-flop synchronizer followed by a
// counter-based debouncer. The debounced level only changes after the
// synchronized input has disagreed with it for 2^DEBOUNCE_BITS cycles.
module sys_ctl_debounce
    import sys_ctl_pkg::*;
#(
    parameter int DEBOUNCE_BITS = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic din_n,
    output logic dout_n
);

    logic                     sync1;
    logic                     sync2;
    logic [DEBOUNCE_BITS-1:0] cnt;

    // Synchronize the asynchronous button and debounce the synchronized level.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1  <= 1'b1;
            sync2  <= 1'b1;
            dout_n <= 1'b1;
            cnt    <= '0;
        end else begin
            sync1 <= din_n;
            sync2 <= sync1;
            if (sync2 == dout_n) begin
                cnt <= '0;
            end else if (&cnt) begin
                dout_n <= sync2;
                cnt    <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/sys_ctl.sv
// sys_ctl: CPU reset stretcher and clock-enable generator.
// Optional feature macro: SYS_CTL_TURBO_EN adds the 2-bit turbo input that
// divides the cpu_clken divisor by 1, 2, 4 or 8; without it the divisor is
// fixed at CLK_DIV.
module sys_ctl
    import sys_ctl_pkg::*;
#(
    parameter int POR_CYCLES    = 1024,
    parameter int DEBOUNCE_BITS = 16,
    parameter int CLK_DIV       = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rst_btn_n,
`ifdef SYS_CTL_TURBO_EN
    input  logic [1:0] turbo,
`endif
    output logic       cpu_clken,
    output logic       cpu_reset_n
);

    localparam int POR_W = (POR_CYCLES > 2) ? $clog2(POR_CYCLES) : 1;
    localparam int DIV_W = $clog2(CLK_DIV);
    localparam logic [POR_W-1:0] POR_LAST = POR_W'(POR_CYCLES - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    // ------------------------------------------------------------------
    // Button conditioning
    // ------------------------------------------------------------------
    logic btn_db_n;

    sys_ctl_debounce #(
        .DEBOUNCE_BITS(DEBOUNCE_BITS)
    ) u_debounce (
        .clk   (clk),
        .reset (reset),
        .din_n (rst_btn_n),
        .dout_n(btn_db_n)
    );

    // ------------------------------------------------------------------
    // Clock-enable divider
    // ------------------------------------------------------------------
    logic [DIV_W-1:0] div;
    logic [DIV_W-1:0] div_last;
    logic             div_wrap;
    logic             wrap_q;

`ifdef SYS_CTL_TURBO_EN
    logic [1:0] turbo_eff;

    // Take a new turbo setting only at wrap so no period is cut short.
    always_ff @(posedge clk) begin
        if (reset) begin
            turbo_eff <= TURBO_X1;
        end else if (div_wrap) begin
            turbo_eff <= turbo;
        end
    end

    // CLK_DIV is a power of two, so (CLK_DIV >> t) - 1 == (CLK_DIV - 1) >> t.
    assign div_last = DIV_LAST >> turbo_eff;
`else
    assign div_last = DIV_LAST;
`endif

    assign div_wrap = (div == div_last);

    // Free-running divider; the wrap flag is retimed twice so the first
    // strobe lands after edge CLK_DIV + 1 and each later one D cycles on.
    always_ff @(posedge clk) begin
        if (reset) begin
            div       <= '0;
            wrap_q    <= 1'b0;
            cpu_clken <= 1'b0;
        end else begin
            div       <= div_wrap ? '0 : div + 1'b1;
            wrap_q    <= div_wrap;
            cpu_clken <= wrap_q;
        end
    end

    // ------------------------------------------------------------------
    // Reset sequencer
    // ------------------------------------------------------------------
    sys_state_t       state;
    sys_state_t       state_next;
    logic [POR_W-1:0] por_cnt;
    logic [POR_W-1:0] por_cnt_next;
    logic             btn_pressed;

    assign btn_pressed = ~btn_db_n;

    // State register, POR counter and the registered CPU reset output.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= HOLD;
            por_cnt     <= '0;
            cpu_reset_n <= 1'b0;
        end else begin
            state       <= state_next;
            por_cnt     <= por_cnt_next;
            cpu_reset_n <= (state == RUN);
        end
    end

    // Next-state logic: stretch in HOLD, run, or wait for button release.
    always_comb begin
        state_next   = state;
        por_cnt_next = por_cnt;
        case (state)
            HOLD: begin
                if (btn_pressed) begin
                    state_next   = BTN;
                    por_cnt_next = '0;
                end else if (por_cnt == POR_LAST) begin
                    state_next   = RUN;
                    por_cnt_next = '0;
                end else begin
                    por_cnt_next = por_cnt + 1'b1;
                end
            end
            RUN: begin
                por_cnt_next = '0;
                if (btn_pressed) begin
                    state_next = BTN;
                end
            end
            BTN: begin
                por_cnt_next = '0;
                if (!btn_pressed) begin
                    state_next = HOLD;
                end
            end
            default: begin
                state_next   = HOLD;
                por_cnt_next = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_sys_ctl.sv
// Directed bench for sys_ctl with POR_CYCLES=16, DEBOUNCE_BITS=3, CLK_DIV=8.
// Expected {cpu_clken, cpu_reset_n} pairs are pushed per edge from edge
// numbers derived from the timing description, then popped and compared.
module tb_sys_ctl;
    import sys_ctl_pkg::*;

    localparam int POR = 16;
    localparam int DBB = 3;
    localparam int DIV = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic       rst_btn_n;
    logic       cpu_clken;
    logic       cpu_reset_n;
`ifdef SYS_CTL_TURBO_EN
    logic [1:0] turbo;
`endif

    int         n_tests = 0;
    int         n_fail  = 0;
    int         e       = 0;
    logic [1:0] exp_q[$];

    sys_ctl #(
        .POR_CYCLES   (POR),
        .DEBOUNCE_BITS(DBB),
        .CLK_DIV      (DIV)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rst_btn_n  (rst_btn_n),
`ifdef SYS_CTL_TURBO_EN
        .turbo      (turbo),
`endif
        .cpu_clken  (cpu_clken),
        .cpu_reset_n(cpu_reset_n)
    );

    // Clock
    always #5 clk = ~clk;

    // Base-rate strobe: first after edge DIV+1, then every DIV edges.
    function automatic logic base_clken(input int edge_n);
        return (edge_n >= DIV + 1) && ((edge_n % DIV) == 1);
    endfunction

    // Driver side: queue the expected outputs for the next edge.
    task automatic push_exp(input logic clken, input logic rstn);
        exp_q.push_back({clken, rstn});
    endtask

    // Advance one edge, sample #1 later, pop and compare.
    task automatic step(input string tag);
        logic [1:0] expv;
        logic [1:0] obs;
        @(posedge clk);
        e++;
        #1;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL %s edge %0d: scoreboard empty", tag, e);
        end else begin
            expv = exp_q.pop_front();
            obs  = {cpu_clken, cpu_reset_n};
            n_tests++;
            assert (obs === expv) else begin
                n_fail++;
                $error("FAIL %s edge %0d: clken/rst_n observed %b expected %b", tag, e, obs, expv);
            end
        end
    endtask

    initial begin
        reset     = 1'b1;
        rst_btn_n = 1'b1;
`ifdef SYS_CTL_TURBO_EN
        turbo     = TURBO_X1;
`endif

        // Reset held for 5 edges: everything low.
        for (int i = 0; i < 5; i++) begin
            push_exp(1'b0, 1'b0);
            step("reset");
        end

        // Power-on stretch and first strobes.
        reset = 1'b0;
        e     = 0;
        for (int i = 1; i <= 40; i++) begin
            push_exp(base_clken(i), i >= POR + 1);
            step("power_on");
        end

        // Button press for 20 edges (fall before edge 41, release before 61).
        // Press: low 12 cycles after the fall (edge 52).
        // Release: low through edge 61-1+27 = 87, high again at 88.
        rst_btn_n = 1'b0;
        for (int i = 41; i <= 100; i++) begin
            if (i == 61) rst_btn_n = 1'b1;
            push_exp(base_clken(i), !(i >= 52 && i <= 87));
            step("button");
        end

        // Glitch of 7 edges (longest that must be ignored).
        for (int i = 101; i <= 130; i++) begin
            if (i == 101) rst_btn_n = 1'b0;
            if (i == 108) rst_btn_n = 1'b1;
            push_exp(base_clken(i), 1'b1);
            step("glitch");
        end

        // Press again to reach BTN (state at 141, output low at 142).
        for (int i = 131; i <= 149; i++) begin
            if (i == 131) rst_btn_n = 1'b0;
            push_exp(base_clken(i), i < 142);
            step("press2");
        end

        // Reset sampled at edge 150 while in BTN with the divider at 5.
        reset = 1'b1;
        push_exp(1'b0, 1'b0);
        step("reset_mid");

        // Full power-on sequence restarts.
        reset     = 1'b0;
        rst_btn_n = 1'b1;
        e         = 0;
        for (int i = 1; i <= 40; i++) begin
            push_exp(base_clken(i), i >= POR + 1);
            step("restart");
        end

`ifdef SYS_CTL_TURBO_EN
        // /4 requested mid-period: takes over after the wrap at edge 48.
        // /1 requested before 65: takes over after the wrap at edge 68.
        // /8 requested before 81: wrap at 81, next strobe at 90.
        for (int i = 41; i <= 100; i++) begin
            logic ck;
            if (i == 44) turbo = TURBO_X2;
            if (i == 65) turbo = TURBO_X8;
            if (i == 81) turbo = TURBO_X1;
            if (i <= 48)      ck = base_clken(i);
            else if (i <= 68) ck = (i % 4) == 1;
            else if (i <= 82) ck = 1'b1;
            else              ck = (i % 8) == 2;
            push_exp(ck, 1'b1);
            step("turbo");
        end
`else
        // Fixed divisor: period stays 8 regardless of other activity.
        for (int i = 41; i <= 100; i++) begin
            push_exp(base_clken(i), 1'b1);
            step("fixed_div");
        end
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
